// File: rtl/shift_sequencer.sv
// shift_sequencer: load-and-shift register with a valid/ready load handshake.
// A parallel word and a shift count are loaded in IDLE, then the word is
// shifted one bit per enabled cycle (left or right), filled from ser_in, and
// done pulses for one cycle once the count is exhausted.
// Optional feature macro: SHIFT_ROTATE_EN (fill from the bit shifted out).
module shift_sequencer #(
    parameter  int WIDTH = 16,
    localparam int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             load_dir,
    input  logic             load_rot,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] value,
    output logic             msb,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             dir_q,   dir_d;
    logic [LEN_W-1:0] len_clamped;
    logic             fill;

    // Outgoing bit depends only on registered direction and contents.
    assign ser_out = dir_q ? value_q[0] : value_q[WIDTH-1];

`ifdef SHIFT_ROTATE_EN
    logic rot_q, rot_d;

    // Rotate recirculates the outgoing bit; otherwise fill from the serial input.
    always_comb begin
        fill = rot_q ? ser_out : ser_in;
    end
`else
    logic unused_load_rot;
    assign unused_load_rot = load_rot;

    // Without rotate support the vacated bit always comes from ser_in.
    always_comb begin
        fill = ser_in;
    end
`endif

    // Counts above WIDTH are clamped to a full-word shift.
    always_comb begin
        len_clamped = load_len;
        if (load_len > LEN_W'(WIDTH)) begin
            len_clamped = LEN_W'(WIDTH);
        end
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
        dir_d   = dir_q;
`ifdef SHIFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    value_d = load_data;
                    dir_d   = load_dir;
                    count_d = len_clamped;
`ifdef SHIFT_ROTATE_EN
                    rot_d   = load_rot;
`endif
                    state_d = (len_clamped == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (dir_q) begin
                        value_d = {fill, value_q[WIDTH-1:1]};
                    end else begin
                        value_d = {value_q[WIDTH-2:0], fill};
                    end
                    count_d = count_q - 1'b1;
                    if (count_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            count_q <= count_d;
            dir_q   <= dir_d;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign value      = value_q;
    assign msb        = value_q[WIDTH-1];

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard testbench for shift_sequencer: directed cases plus random loads,
// checked against an arithmetic shift/rotate reference model.
module tb_shift_sequencer;

    localparam int W  = 16;
    localparam int LW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic [LW-1:0] load_len;
    logic          load_dir;
    logic          load_rot;
    logic          shift_en;
    logic          ser_in;
    logic [W-1:0]  value;
    logic          msb;
    logic          ser_out;
    logic          busy;
    logic          done;

    shift_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_dir   (load_dir),
        .load_rot   (load_rot),
        .shift_en   (shift_en),
        .ser_in     (ser_in),
        .value      (value),
        .msb        (msb),
        .ser_out    (ser_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [W-1:0] value;
        int           cycle;
    } exp_t;
    exp_t sb[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Result of k single-bit shifts of d, computed directly as a multi-bit shift.
    function automatic logic [W-1:0] model(logic [W-1:0] d, int k, bit dir, bit rot, bit s);
        longint unsigned x    = 64'(d);
        longint unsigned mask = (64'd1 << W) - 1;
        longint unsigned ones = (64'd1 << k) - 1;
        longint unsigned r;
        if (!dir) r = rot ? ((x << k) | (x >> (W - k))) : ((x << k) | (s ? ones : 64'd0));
        else      r = rot ? ((x >> k) | (x << (W - k))) : ((x >> k) | (s ? (ones << (W - k)) : 64'd0));
        return W'(r & mask);
    endfunction

    function automatic bit rot_effective(bit rot);
`ifdef SHIFT_ROTATE_EN
        return rot;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (mon_en && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_value", 32'(value), 32'(e.value));
                chk("done_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
    end

    // mode 0: shift_en held high, 1: random, 2: pattern bits from pat.
    task automatic run_load(input logic [W-1:0] d, input int len, input bit dir,
                            input bit rot, input bit s, input int mode,
                            input logic [7:0] pat, input bit glitch);
        int n = (len > W) ? W : len;
        bit en_arr[$];
        int shifts = 0;
        int c = 0;
        int h;
        int waited = 0;
        bit re = rot_effective(rot);
        logic [W-1:0] ev;

        @(negedge clk);
        while (!load_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_load", 32'(load_ready), 32'd1);

        @(posedge clk); #1;
        load_valid = 1'b1;
        load_data  = d;
        load_len   = LW'(len);
        load_dir   = dir;
        load_rot   = rot;
        ser_in     = s;
        shift_en   = 1'($urandom_range(0, 1));
        h = cyc;

        while (shifts < n) begin
            bit e;
            if (mode == 0)      e = 1'b1;
            else if (mode == 1) e = ($urandom_range(0, 3) != 0);
            else                e = (c < 8) ? pat[c] : 1'b1;
            en_arr.push_back(e);
            if (e) shifts++;
            c++;
        end
        sb.push_back('{model(d, n, dir, re, s), h + 1 + en_arr.size()});

        shifts = 0;
        foreach (en_arr[i]) begin
            @(posedge clk); #1;
            load_valid = glitch;
            load_data  = W'($urandom);
            load_len   = LW'($urandom_range(0, W));
            shift_en   = en_arr[i];
            @(negedge clk);
            ev = model(d, shifts, dir, re, s);
            chk("shift_value", 32'(value), 32'(ev));
            chk("shift_ser_out", 32'(ser_out), 32'(dir ? ev[0] : ev[W-1]));
            chk("shift_msb", 32'(msb), 32'(ev[W-1]));
            chk("shift_busy", 32'(busy), 32'd1);
            chk("shift_ready", 32'(load_ready), 32'd0);
            if (en_arr[i]) shifts++;
        end

        @(posedge clk); #1;
        load_valid = glitch;
        shift_en   = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done_state_value", 32'(value), 32'(model(d, n, dir, re, s)));
        chk("done_state_busy", 32'(busy), 32'd1);
        chk("done_state_ready", 32'(load_ready), 32'd0);

        @(posedge clk); #1;
        load_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(load_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_hold", 32'(value), 32'(model(d, n, dir, re, s)));
    endtask

    // Abort a 3-shift load after two shifts; no done may follow.
    task automatic reset_midop();
        @(posedge clk); #1;
        load_valid = 1'b1; load_data = 16'h0F0F; load_len = LW'(3);
        load_dir = 1'b0; load_rot = 1'b0; ser_in = 1'b0; shift_en = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            load_valid = 1'b0;
            shift_en   = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_pre_value", 32'(value), 32'h3C3C);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        shift_en = 1'b0;
        @(negedge clk);
        chk("abort_value", 32'(value), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(load_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_len = '0;
        load_dir = 1'b0; load_rot = 1'b0; shift_en = 1'b1; ser_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_value", 32'(value), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ready", 32'(load_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        shift_en = 1'b0;
        mon_en = 1'b1;

        run_load(16'hA5A5, 4, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        run_load(16'h0001, 3, 1'b1, 1'b0, 1'b1, 0, 8'h00, 1'b0);
        run_load(16'h1234, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        run_load(16'hFFFF, 20, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        run_load(16'h0F0F, 3, 1'b0, 1'b0, 1'b0, 2, 8'h19, 1'b0);
        run_load(16'h0F0F, 3, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
        reset_midop();
        run_load(16'h8001, 1, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
        run_load(16'h8001, 1, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0);
        run_load(16'h8001, 1, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        run_load(16'h8001, 1, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_load(W'($urandom), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)), 8'h00, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
